// File: rtl/xor_accum_pkg.sv
// xor_accum_pkg: shared types and helpers for the XOR accumulator bank.
//   ch_state_e  - per-lane frame state (idle / accumulating / complete).
//   count_width - width of a word counter that can hold the value BURST.
package xor_accum_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDone  = 2'd2
  } ch_state_e;

  function automatic int unsigned count_width(input int unsigned burst);
    return (burst < 1) ? 1 : $clog2(burst + 1);
  endfunction

endpackage

// File: rtl/xor_accum_channel.sv
// xor_accum_channel: one accumulator lane of the XOR bank.
//   clk, rst   - clock, synchronous active-high reset
//   en         - global enable; low clears an idle/accumulating frame
//   accept     - a word for this lane is taken this cycle
//   drain      - the completed frame of this lane is taken downstream
//   flush      - close a partial frame (only honoured while accumulating)
//   in_data    - input word
//   state      - lane state
//   acc        - running XOR signature
//   count      - words folded into the current frame
module xor_accum_channel
  import xor_accum_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BURST = 16,
  parameter int unsigned CW    = count_width(BURST)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             accept,
  input  logic             drain,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  output ch_state_e        state,
  output logic [WIDTH-1:0] acc,
  output logic [CW-1:0]    count
);

  localparam logic [CW-1:0] BurstCount = CW'(BURST);

  logic [CW-1:0] count_inc;

  always_comb begin
    count_inc = count + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= StIdle;
      acc   <= '0;
      count <= '0;
    end else if (drain) begin
      state <= StIdle;
      acc   <= '0;
      count <= '0;
    end else if (state == StDone) begin
      // Completed frame is held until drained, regardless of en.
      state <= StDone;
    end else if (!en) begin
      state <= StIdle;
      acc   <= '0;
      count <= '0;
    end else if (accept) begin
      // A flush in the same cycle keeps the word, then closes the frame.
      acc   <= acc ^ in_data;
      count <= count_inc;
      state <= ((count_inc == BurstCount) || flush) ? StDone : StAccum;
    end else if (flush && (state == StAccum)) begin
      state <= StDone;
    end
  end

endmodule

// File: rtl/xor_accum_bank.sv
// xor_accum_bank: CHANNELS independent XOR accumulators, each folding BURST
// words into a frame signature; completed frames leave through one
// valid/ready port, lowest channel index first.
//   clk, rst               - clock, synchronous active-high reset
//   en                     - global enable (low clears in-progress frames)
//   in_valid/in_ch/in_data - input word and its target channel
//   in_ready               - input word can be accepted this cycle
//   out_valid/out_ch/out_data - presented completed frame
//   out_ready              - downstream accepts the presented frame
// Optional feature, enabled by defining XOR_ACCUM_FLUSH_EN:
//   flush[CHANNELS]        - close a partial frame on an accumulating channel
//   out_len                - word count of the presented frame
module xor_accum_bank
  import xor_accum_pkg::*;
#(
  parameter  int unsigned WIDTH    = 8,
  parameter  int unsigned CHANNELS = 4,
  parameter  int unsigned BURST    = 16,
  localparam int unsigned CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int unsigned CW       = count_width(BURST)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                in_valid,
  input  logic [CHW-1:0]      in_ch,
  input  logic [WIDTH-1:0]    in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [CHW-1:0]      out_ch,
  output logic [WIDTH-1:0]    out_data,
`ifdef XOR_ACCUM_FLUSH_EN
  input  logic [CHANNELS-1:0] flush,
  output logic [CW-1:0]       out_len,
`endif
  input  logic                out_ready
);

  ch_state_e           state [CHANNELS];
  logic [WIDTH-1:0]    acc   [CHANNELS];
  logic [CHANNELS-1:0] done;
  logic [CHANNELS-1:0] accept;
  logic [CHANNELS-1:0] drain;
  logic                in_range;
  logic                target_done;
  logic [CHW-1:0]      sel;
  logic                any_done;

`ifdef XOR_ACCUM_FLUSH_EN
  logic [CW-1:0]       count [CHANNELS];
`endif

  // Input-side decode. The per-channel compare avoids indexing past the
  // lane array when in_ch is out of range.
  always_comb begin
    in_range    = 32'(in_ch) < CHANNELS;
    target_done = 1'b0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      if (in_ch == CHW'(c)) target_done = done[c];
    end
    in_ready = ~rst & en & in_range & ~target_done;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      accept[c] = in_valid & in_ready & (in_ch == CHW'(c));
    end
  end

  // Lowest-index DONE channel wins: scan downwards so the last hit is lowest.
  always_comb begin
    any_done = 1'b0;
    sel      = '0;
    out_data = '0;
`ifdef XOR_ACCUM_FLUSH_EN
    out_len  = '0;
`endif
    for (int c = int'(CHANNELS) - 1; c >= 0; c--) begin
      if (done[c]) begin
        any_done = 1'b1;
        sel      = CHW'(c);
        out_data = acc[c];
`ifdef XOR_ACCUM_FLUSH_EN
        out_len  = count[c];
`endif
      end
    end
    out_valid = any_done;
    out_ch    = sel;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      drain[c] = any_done & out_ready & (sel == CHW'(c));
    end
  end

  for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_ch
    assign done[g] = (state[g] == StDone);

    xor_accum_channel #(
      .WIDTH (WIDTH),
      .BURST (BURST),
      .CW    (CW)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .accept  (accept[g]),
      .drain   (drain[g]),
`ifdef XOR_ACCUM_FLUSH_EN
      .flush   (flush[g]),
      .count   (count[g]),
`else
      .flush   (1'b0),
      .count   (),
`endif
      .in_data (in_data),
      .state   (state[g]),
      .acc     (acc[g])
    );
  end

endmodule
